// File: rtl/cpu_defs.sv
// Shared definitions for the instruction-memory load path: loader state encoding and
// word/byte geometry.
package cpu_defs;

  localparam int unsigned IM_ADDR_W      = 6;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes into a 32-bit word by shifting; endian select decides whether the
// first byte ends up in the top or bottom lane.
module byte_packer
  import cpu_defs::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_full_c
);

  logic [BIDX_W-1:0] idx;
  logic [WORD_W-1:0] shreg;

  // word_c already contains the byte being accepted, so it is complete on the 4th accept
  always_comb begin
    word_c      = BIG_ENDIAN ? {shreg[WORD_W-BYTE_W-1:0], byte_in}
                             : {byte_in, shreg[WORD_W-1:BYTE_W]};
    word_full_c = accept && (idx == BIDX_W'(BYTES_PER_WORD - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      shreg <= '0;
    end else if (clear) begin
      idx   <= '0;
      shreg <= '0;
    end else if (accept) begin
      idx   <= idx + BIDX_W'(1);
      shreg <= word_c;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a byte stream into instruction memory as 32-bit words and holds the CPU in reset
// until the requested number of words has been written.
module inst_mem_loader
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W     = IM_ADDR_W,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [WORD_W-1:0] IM_W_Data,
  output logic              IM_Write,
  output logic              CPU_Reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned      CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

  loader_state_e    state, state_nxt;
  logic [CNT_W-1:0] words_left;
  logic [CNT_W-1:0] wc_clamp_c;
  logic             start_ok_c, err_c, accept_c, last_word_c;
  logic [WORD_W-1:0] word_c;
  logic             word_full_c;

  byte_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
    .clk         (clk),
    .rst_n       (Reset_n),
    .clear       (start_ok_c),
    .accept      (accept_c),
    .byte_in     (byte_in),
    .word_c      (word_c),
    .word_full_c (word_full_c)
  );

  // Next-state and handshake decode; DONE counts as idle for start acceptance
  always_comb begin
    state_nxt   = state;
    start_ok_c  = start && ((state == ST_IDLE) || (state == ST_DONE));
    err_c       = start && ((state == ST_RECV) || (state == ST_WRITE));
    accept_c    = byte_valid && byte_ready;
    last_word_c = (words_left == CNT_W'(1));
    wc_clamp_c  = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok_c)
          state_nxt = (wc_clamp_c == '0) ? ST_DONE : ST_RECV;
        else if (state == ST_DONE)
          state_nxt = ST_IDLE;
      end
      ST_RECV:  if (word_full_c) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = last_word_c ? ST_DONE : ST_RECV;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      IM_Write   <= 1'b0;
      IM_Addr    <= '0;
      IM_W_Data  <= '0;
      words_left <= '0;
      CPU_Reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_ready <= (state_nxt == ST_RECV);
      busy       <= (state_nxt == ST_RECV) || (state_nxt == ST_WRITE);
      IM_Write   <= (state_nxt == ST_WRITE);
      err        <= err_c;
      if (word_full_c)
        IM_W_Data <= word_c;
      // address holds on the final write so it never wraps past the top word
      if (start_ok_c) begin
        IM_Addr    <= '0;
        words_left <= wc_clamp_c;
      end else if (state == ST_WRITE) begin
        words_left <= words_left - CNT_W'(1);
        if (!last_word_c)
          IM_Addr <= IM_Addr + ADDR_W'(1);
      end
      if (state_nxt == ST_DONE) begin
        CPU_Reset <= 1'b0;
        done      <= 1'b1;
      end else if (start_ok_c) begin
        CPU_Reset <= 1'b1;
        done      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: big- and little-endian instances share one stimulus stream and
// are checked against a write-queue model built from the byte program.
module tb_inst_mem_loader;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;

  logic        ready_be, wr_be, cpu_rst_be, busy_be, done_be, err_be;
  logic [5:0]  addr_be;
  logic [31:0] data_be;
  logic        ready_le, wr_le, cpu_rst_le, busy_le, done_le, err_le;
  logic [5:0]  addr_le;
  logic [31:0] data_le;

  int tests = 0;
  int failed = 0;
  int n_wr = 0;
  int n0;

  wr_t         exp_be[$];
  wr_t         exp_le[$];
  logic [31:0] log_be [0:63];
  logic [31:0] log_le [0:63];
  logic [7:0]  prog   [0:255];

  inst_mem_loader #(.ADDR_W(6), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .Reset_n(rst_n), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_be),
    .IM_Addr(addr_be), .IM_W_Data(data_be), .IM_Write(wr_be),
    .CPU_Reset(cpu_rst_be), .busy(busy_be), .done(done_be), .err(err_be)
  );

  inst_mem_loader #(.ADDR_W(6), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .Reset_n(rst_n), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_le),
    .IM_Addr(addr_le), .IM_W_Data(data_le), .IM_Write(wr_le),
    .CPU_Reset(cpu_rst_le), .busy(busy_le), .done(done_le), .err(err_le)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int base, input bit be);
    logic [7:0] b0, b1, b2, b3;
    b0 = prog[base]; b1 = prog[base+1]; b2 = prog[base+2]; b3 = prog[base+3];
    return be ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
  endfunction

  // Every write of either instance must match the next expected (addr, data)
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_be) begin
        if (exp_be.size() == 0) begin
          tests++; failed++;
          $display("FAIL be_unexpected_write: got addr %0d data %h expected no write", addr_be, data_be);
        end else begin
          wr_t e;
          e = exp_be.pop_front();
          chk("be_addr", 32'(addr_be), 32'(e.addr));
          chk("be_data", data_be, e.data);
        end
        chk("be_cpu_reset_during_write", 32'(cpu_rst_be), 32'd1);
        log_be[addr_be] = data_be;
        n_wr++;
      end
      if (wr_le) begin
        if (exp_le.size() == 0) begin
          tests++; failed++;
          $display("FAIL le_unexpected_write: got addr %0d data %h expected no write", addr_le, data_le);
        end else begin
          wr_t e;
          e = exp_le.pop_front();
          chk("le_addr", 32'(addr_le), 32'(e.addr));
          chk("le_data", data_le, e.data);
        end
        log_le[addr_le] = data_le;
      end
    end
  end

  // Called at a negedge; a start is accepted by the model only when no writes are pending
  task automatic do_start(input int n, input int base);
    bit acc;
    int nw;
    acc = (exp_be.size() == 0);
    nw  = (n > 64) ? 64 : n;
    word_count = 7'(n);
    start = 1'b1;
    if (acc) begin
      for (int w = 0; w < nw; w++) begin
        wr_t e;
        e.addr = 6'(w);
        e.data = pack(base + 4*w, 1'b1);
        exp_be.push_back(e);
        e.data = pack(base + 4*w, 1'b0);
        exp_le.push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;
    word_count = 7'd3;
    chk("err_on_start", 32'(err_be), 32'(!acc));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!ready_be && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      tests++; failed++;
      $display("FAIL byte_ready_timeout: got ready 0 expected ready within 200 cycles");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit gap);
    for (int i = lo; i < hi; i++) begin
      send_byte(prog[i]);
      if (gap && (i % 4 == 1)) repeat (2) @(negedge clk);
    end
  endtask

  task automatic set_prog8(input logic [63:0] v);
    for (int i = 0; i < 8; i++) prog[i] = v[63-8*i -: 8];
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin log_be[i] = '0; log_le[i] = '0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset state, no writes while idle
    repeat (20) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_rst_be), 32'd1);
    chk("rst_byte_ready", 32'(ready_be), 32'd0);
    chk("rst_done", 32'(done_be), 32'd0);
    chk("rst_busy", 32'(busy_be), 32'd0);
    chk("rst_addr", 32'(addr_be), 32'd0);
    chk("rst_no_writes", 32'(n_wr), 32'd0);

    // 2/3: two-word program, both endians
    set_prog8(64'h0022402000641822);
    do_start(2, 0);
    chk("load_busy", 32'(busy_be), 32'd1);
    send_range(0, 8, 1'b0);
    chk("write_cycle_cpu_reset", 32'(cpu_rst_be), 32'd1);
    chk("write_cycle_done", 32'(done_be), 32'd0);
    @(negedge clk);
    chk("done_after_last_write", 32'(done_be), 32'd1);
    chk("cpu_release", 32'(cpu_rst_be), 32'd0);
    chk("busy_after_load", 32'(busy_be), 32'd0);
    #1;
    chk("be_word0", log_be[0], 32'h00224020);
    chk("be_word1", log_be[1], 32'h00641822);
    chk("le_word0", log_le[0], 32'h20402200);
    chk("le_word1", log_le[1], 32'h22186400);
    chk("queue_drained_2", 32'(exp_be.size()), 32'd0);
    @(negedge clk);
    chk("done_level_held", 32'(done_be), 32'd1);

    // 3: valid toggled mid-word gives the same words and no extra writes
    for (int i = 0; i < 64; i++) begin log_be[i] = '0; log_le[i] = '0; end
    n0 = n_wr;
    do_start(2, 0);
    send_range(0, 8, 1'b1);
    @(negedge clk); #1;
    chk("gap_le_word0", log_le[0], 32'h20402200);
    chk("gap_be_word1", log_be[1], 32'h00641822);
    chk("gap_write_count", 32'(n_wr - n0), 32'd2);

    // 4: zero-length load
    n0 = n_wr;
    do_start(0, 0);
    chk("zero_done", 32'(done_be), 32'd1);
    chk("zero_cpu_reset", 32'(cpu_rst_be), 32'd0);
    @(negedge clk);
    chk("zero_done_2", 32'(done_be), 32'd1);
    chk("zero_cpu_reset_2", 32'(cpu_rst_be), 32'd0);
    chk("zero_busy", 32'(busy_be), 32'd0);
    chk("zero_no_writes", 32'(n_wr - n0), 32'd0);

    // 4: oversize count clamps to 64 words at addresses 0..63
    for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
    n0 = n_wr;
    do_start(100, 0);
    send_range(0, 256, 1'b0);
    @(negedge clk);
    chk("clamp_write_count", 32'(n_wr - n0), 32'd64);
    chk("clamp_final_addr", 32'(addr_be), 32'd63);
    chk("clamp_cpu_release", 32'(cpu_rst_be), 32'd0);
    chk("clamp_ready_low", 32'(ready_be), 32'd0);
    #1;
    chk("clamp_queue_drained", 32'(exp_be.size()), 32'd0);
    @(negedge clk);

    // 5: start during RECV is rejected with an err pulse
    set_prog8(64'hDEADBEEF_01234567);
    n0 = n_wr;
    do_start(1, 0);
    send_range(0, 2, 1'b0);
    do_start(5, 4);
    @(negedge clk);
    chk("err_pulse_width", 32'(err_be), 32'd0);
    send_range(2, 4, 1'b0);
    @(negedge clk); #1;
    chk("err_load_done", 32'(done_be), 32'd1);
    chk("err_load_writes", 32'(n_wr - n0), 32'd1);
    chk("err_be_word", log_be[0], 32'hDEADBEEF);
    chk("err_le_word", log_le[0], 32'hEFBEADDE);
    @(negedge clk);

    // 5: reset mid-load
    do_start(2, 0);
    send_range(0, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cpu_reset", 32'(cpu_rst_be), 32'd1);
    chk("mid_rst_ready", 32'(ready_be), 32'd0);
    chk("mid_rst_busy", 32'(busy_be), 32'd0);
    chk("mid_rst_done", 32'(done_be), 32'd0);
    chk("mid_rst_write", 32'(wr_be), 32'd0);
    chk("mid_rst_data", data_be, 32'd0);
    exp_be.delete();
    exp_le.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 6: start in the DONE cycle begins a new load
    set_prog8(64'h8C0100048C020008);
    n0 = n_wr;
    do_start(1, 0);
    send_range(0, 4, 1'b0);
    @(negedge clk);
    chk("done_cycle_done", 32'(done_be), 32'd1);
    do_start(1, 4);
    chk("restart_cpu_reset", 32'(cpu_rst_be), 32'd1);
    chk("restart_done_clear", 32'(done_be), 32'd0);
    chk("restart_busy", 32'(busy_be), 32'd1);
    send_range(4, 8, 1'b0);
    @(negedge clk); #1;
    chk("restart_done", 32'(done_be), 32'd1);
    chk("restart_writes", 32'(n_wr - n0), 32'd2);
    chk("restart_be_word", log_be[0], 32'h8C020008);
    chk("restart_queue_drained", 32'(exp_be.size() + exp_le.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
